id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Decode stage of the 5-stage pipeline. Holds the 32x32 register file and decodes the IF/ID instruction.
//  Owns the ID/EX pipeline register that feeds the EX ALU directly: operands A, B and the 2-bit ALUOP.
//  Detects load-use hazards: stalls IF/ID and inserts a bubble. Accepts a branch flush from downstream.
// PARAMETERS
//  XLEN   32  datapath width; ex_a/ex_b/wb_data width
//  NREG   32  register count; r0 reads 0 and ignores writes; address width = $clog2(NREG)
// PORTS
//  clk            in   1     pipeline clock, rising edge
//  rst_n          in   1     asynchronous active-low reset
//  if_valid       in   1     if_instr holds a valid instruction
//  if_instr       in   32    instruction from IF/ID register
//  if_stall       out  1     comb; 1 = IF/ID must hold its current instruction this cycle
//  ex_flush       in   1     kill the instruction now in ID and the one entering EX
//  wb_we          in   1     writeback enable
//  wb_addr        in   5     writeback register
//  wb_data        in   XLEN  writeback data
//  ex_valid       out  1     ID/EX register holds a live instruction
//  ex_a           out  XLEN  ALU operand A (rs1 value)
//  ex_b           out  XLEN  ALU operand B (rs2 value or sign-extended imm16)
//  ex_aluop       out  2     0 ADD, 1 SUB, 2 NAND, 3 NOR
//  ex_rd          out  5     destination register
//  ex_we          out  1     instruction writes ex_rd
//  ex_mem_rd      out  1     load
//  ex_mem_wr      out  1     store
//  ex_store_data  out  XLEN  store data (value of reg[instr[25:21]])
// BEHAVIOUR
//  Format: op=[31:26] rd=[25:21] rs1=[20:16] rs2=[15:11] funct=[1:0] imm=[15:0], imm sign-extended to XLEN.
//  op 0x00 R: A=rs1, B=rs2, aluop=funct, we=1.  op 0x08 ADDI: B=imm, aluop=0, we=1.
//  op 0x23 LW: B=imm, aluop=0, we=1, mem_rd=1.  op 0x2B SW: B=imm, aluop=0, we=0, mem_wr=1, store_data=reg[rd].
//  Any other op: decoded as a bubble (ex_valid=0, all control outputs 0).
//  we=0 or rd=0 forces ex_we=0.
//  Latency: 1 cycle. The instruction sampled at edge N appears on ex_* after edge N.
//  Load-use hazard: hz = ex_valid & ex_mem_rd & ex_rd!=0 & if_valid & (ex_rd==rs1 | ex_rd==rs2-used).
//   rs2-used: rs2 field for R-type; rd field for SW.
//   On hz: if_stall=1 and the ID/EX register loads a bubble. The instruction is re-decoded the next cycle.
//  Flush: if ex_flush=1, the ID/EX register loads a bubble and if_stall=0. Flush overrides hz.
//  Bubble: ex_valid, ex_we, ex_mem_rd and ex_mem_wr are 0. Data fields are don't-care but are driven 0.
//  Regfile: one write port, written at the rising edge when wb_we=1 & wb_addr!=0. Three combinational read ports.
//  Async reset: all ex_* outputs = 0 and all registers = 0. if_stall=0 while in reset.
//   A reset asserted mid-stall drops the stall immediately.
//  Simultaneous wb write and ID read of the same register: depends on WB_BYPASS_EN (see CONFIGURATION).
// CONFIGURATION
//  WB_BYPASS_EN defined: the regfile is write-through.
//   A read of wb_addr while wb_we=1 (and wb_addr!=0) returns wb_data in the same cycle.
//  WB_BYPASS_EN undefined: a same-cycle read returns the old stored value.
//   The compiler/scheduler must keep at least 1 instruction of separation. No extra stall is inserted.
// STRUCTURE
//  id_pkg: opcode localparams (OP_R, OP_ADDI, OP_LW, OP_SW).
//   ALUOP encodings (ALU_ADD, ALU_SUB, ALU_NAND, ALU_NOR), shared with EX.
//   Instruction field bit positions.
//  Sub-module id_regfile: NREG x XLEN, r0 hardwired, three read ports and one write port.
//   Holds the WB_BYPASS_EN mux.
//  Top: decoder (comb), hazard logic (comb), ID/EX register (always_ff, async clear).
// TESTING
//  1 Reset: hold rst_n=0 while if_valid=1 -> all ex_*=0, if_stall=0.
//    Release rst_n -> outputs follow decode 1 cycle later.
//  2 Preload r1=5, r2=3 via wb. R-type SUB rd=3 rs1=1 rs2=2 funct=1 ->
//    next cycle ex_a=5, ex_b=3, ex_aluop=1, ex_rd=3, ex_we=1, ex_valid=1.
//  3 ADDI rd=4 rs1=1 imm=0xFFFF -> ex_b=0xFFFFFFFF, ex_aluop=0.
//    SW rd=2 rs1=1 imm=8 -> ex_store_data=3, ex_mem_wr=1, ex_we=0.
//  4 LW rd=5, then ADD rs1=5 -> the ADD cycle shows if_stall=1 and a bubble on ex_*.
//    The next cycle issues the ADD with if_stall=0. With LW rd=0 there is no stall.
//  5 Same hazard as test 4 with ex_flush=1 in the stall cycle -> if_stall=0, bubble loaded.
//  6 wb_we=1 wb_addr=7 wb_data=0xA5 in the same cycle as a read of r7 -> ex_a=0xA5 with WB_BYPASS_EN.
//    Old value without it. Write to r0 -> reads stay 0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared ID/EX definitions: opcodes, ALU operation encodings and instruction field positions.
// The ALU_* encodings are also consumed by the EX stage.
package id_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_NAND = 2'd2;
    localparam logic [1:0] ALU_NOR  = 2'd3;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS1_HI = 20;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 11;
    localparam int FN_HI  = 1;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

endpackage

// File: rtl/id_regfile.sv
// NREG x XLEN register file: r0 hardwired to zero, one write port, three combinational reads.
// WB_BYPASS_EN selects write-through reads of the register being written this cycle.
module id_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    input  logic [AW-1:0]   ra3,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [XLEN-1:0] rd3
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    function automatic logic [XLEN-1:0] read_port(
        input logic [AW-1:0]   a,
        input logic [XLEN-1:0] stored,
        input logic            w_en,
        input logic [AW-1:0]   w_addr,
        input logic [XLEN-1:0] w_data
    );
        logic [XLEN-1:0] v;
        v = stored;
`ifdef WB_BYPASS_EN
        if (w_en && w_addr == a) begin
            v = w_data;
        end
`else
        if (w_en && w_addr == a && 1'b0) begin
            v = w_data;
        end
`endif
        if (a == '0) begin
            v = '0;
        end
        return v;
    endfunction

    assign rd1 = read_port(ra1, mem[ra1], we, waddr, wdata);
    assign rd2 = read_port(ra2, mem[ra2], we, waddr, wdata);
    assign rd3 = read_port(ra3, mem[ra3], we, waddr, wdata);

endmodule

// File: rtl/id_stage.sv
// Decode stage: register file, instruction decoder, load-use hazard detection and the ID/EX register.
// Optional macro WB_BYPASS_EN makes register file reads write-through (handled in id_regfile).
module id_stage
    import id_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    output logic            if_stall,
    input  logic            ex_flush,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [1:0]      ex_aluop,
    output logic [4:0]      ex_rd,
    output logic            ex_we,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic [XLEN-1:0] ex_store_data
);

    function automatic logic signed [XLEN-1:0] sext_imm(input logic [15:0] imm);
        logic signed [15:0] s;
        s = imm;
        return XLEN'(s);
    endfunction

    logic [5:0]  op_f;
    logic [4:0]  rd_f;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [1:0]  fn_f;
    logic [15:0] imm_f;

    assign op_f  = if_instr[OP_HI:OP_LO];
    assign rd_f  = if_instr[RD_HI:RD_LO];
    assign rs1_f = if_instr[RS1_HI:RS1_LO];
    assign rs2_f = if_instr[RS2_HI:RS2_LO];
    assign fn_f  = if_instr[FN_HI:FN_LO];
    assign imm_f = if_instr[IMM_HI:IMM_LO];

    logic [XLEN-1:0] rs1_v;
    logic [XLEN-1:0] rs2_v;
    logic [XLEN-1:0] rd_v;

    id_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wb_we),
        .waddr (wb_addr),
        .wdata (wb_data),
        .ra1   (rs1_f[AW-1:0]),
        .ra2   (rs2_f[AW-1:0]),
        .ra3   (rd_f[AW-1:0]),
        .rd1   (rs1_v),
        .rd2   (rs2_v),
        .rd3   (rd_v)
    );

    logic                   vld_p1;
    logic [XLEN-1:0]        a_p1;
    logic [XLEN-1:0]        b_p1;
    logic [1:0]             aluop_p1;
    logic [4:0]             rd_p1;
    logic                   we_p1;
    logic                   mrd_p1;
    logic                   mwr_p1;
    logic [XLEN-1:0]        sd_p1;

    // ---- stage p0: decode and hazard detection (combinational) ----
    logic                   known_p0;
    logic signed [XLEN-1:0] b_p0;
    logic [1:0]             aluop_p0;
    logic                   we_p0;
    logic                   mrd_p0;
    logic                   mwr_p0;
    logic [XLEN-1:0]        sd_p0;
    logic                   hz_p0;
    logic                   issue_p0;

    always_comb begin
        known_p0 = 1'b1;
        b_p0     = '0;
        aluop_p0 = ALU_ADD;
        we_p0    = 1'b0;
        mrd_p0   = 1'b0;
        mwr_p0   = 1'b0;
        sd_p0    = '0;
        case (op_f)
            OP_R: begin
                b_p0     = rs2_v;
                aluop_p0 = fn_f;
                we_p0    = 1'b1;
            end
            OP_ADDI: begin
                b_p0  = sext_imm(imm_f);
                we_p0 = 1'b1;
            end
            OP_LW: begin
                b_p0   = sext_imm(imm_f);
                we_p0  = 1'b1;
                mrd_p0 = 1'b1;
            end
            OP_SW: begin
                b_p0   = sext_imm(imm_f);
                mwr_p0 = 1'b1;
                sd_p0  = rd_v;
            end
            default: known_p0 = 1'b0;
        endcase
    end

    // Stores read their data register through the rd field, so it counts as a source.
    assign hz_p0 = vld_p1 && mrd_p1 && (rd_p1 != 5'd0) && if_valid &&
                   ((rd_p1 == rs1_f) ||
                    (op_f == OP_R  && rd_p1 == rs2_f) ||
                    (op_f == OP_SW && rd_p1 == rd_f));

    assign if_stall = hz_p0 && !ex_flush;
    assign issue_p0 = if_valid && known_p0 && !hz_p0 && !ex_flush;

    // ---- stage p1: ID/EX register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            a_p1     <= '0;
            b_p1     <= '0;
            aluop_p1 <= '0;
            rd_p1    <= '0;
            we_p1    <= 1'b0;
            mrd_p1   <= 1'b0;
            mwr_p1   <= 1'b0;
            sd_p1    <= '0;
        end else if (issue_p0) begin
            vld_p1   <= 1'b1;
            a_p1     <= rs1_v;
            b_p1     <= b_p0;
            aluop_p1 <= aluop_p0;
            rd_p1    <= rd_f;
            we_p1    <= we_p0 && (rd_f != 5'd0);
            mrd_p1   <= mrd_p0;
            mwr_p1   <= mwr_p0;
            sd_p1    <= sd_p0;
        end else begin
            vld_p1   <= 1'b0;
            a_p1     <= '0;
            b_p1     <= '0;
            aluop_p1 <= '0;
            rd_p1    <= '0;
            we_p1    <= 1'b0;
            mrd_p1   <= 1'b0;
            mwr_p1   <= 1'b0;
            sd_p1    <= '0;
        end
    end

    assign ex_valid      = vld_p1;
    assign ex_a          = a_p1;
    assign ex_b          = b_p1;
    assign ex_aluop      = aluop_p1;
    assign ex_rd         = rd_p1;
    assign ex_we         = we_p1;
    assign ex_mem_rd     = mrd_p1;
    assign ex_mem_wr     = mwr_p1;
    assign ex_store_data = sd_p1;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed cases followed by randomized traffic against a reference model.
// Build with or without +define+WB_BYPASS_EN; the model follows the same macro.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        if_stall;
    logic        ex_flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [1:0]  ex_aluop;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [31:0] ex_store_data;

    always #5 clk = ~clk;

    id_stage #(.XLEN(32), .NREG(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_stall      (if_stall),
        .ex_flush      (ex_flush),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .ex_valid      (ex_valid),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_aluop      (ex_aluop),
        .ex_rd         (ex_rd),
        .ex_we         (ex_we),
        .ex_mem_rd     (ex_mem_rd),
        .ex_mem_wr     (ex_mem_wr),
        .ex_store_data (ex_store_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---- reference model: architectural registers and the expected EX-side view ----
    typedef struct {
        bit          v;
        bit          we;
        bit          mrd;
        bit          mwr;
        logic [1:0]  aluop;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
    } ex_t;

    logic [31:0] rf [32];
    ex_t         ex_m;
    bit          stall_obs;

    function automatic ex_t bubble();
        ex_t e;
        e.v = 0; e.we = 0; e.mrd = 0; e.mwr = 0;
        e.aluop = 2'd0; e.rd = 5'd0; e.a = 32'd0; e.b = 32'd0; e.sd = 32'd0;
        return e;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        ex_m = bubble();
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (wb_we && wb_addr == r) return wb_data;
`endif
        return rf[r];
    endfunction

    // True when the instruction in ID needs the value the load in EX has not fetched yet.
    function automatic bit m_hazard();
        logic [5:0] op;
        logic [4:0] rd, rs1, rs2;
        op  = if_instr[31:26];
        rd  = if_instr[25:21];
        rs1 = if_instr[20:16];
        rs2 = if_instr[15:11];
        if (!(ex_m.v && ex_m.mrd && ex_m.rd != 0 && if_valid)) return 0;
        return (ex_m.rd == rs1) || (op == 6'h00 && ex_m.rd == rs2) || (op == 6'h2B && ex_m.rd == rd);
    endfunction

    task automatic m_clock();
        ex_t n;
        logic [5:0] op;
        logic [4:0] rd, rs1, rs2;
        logic [31:0] imm;
        n   = bubble();
        op  = if_instr[31:26];
        rd  = if_instr[25:21];
        rs1 = if_instr[20:16];
        rs2 = if_instr[15:11];
        imm = 32'($signed(if_instr[15:0]));
        if (if_valid && !ex_flush && !m_hazard()) begin
            n.rd = rd;
            n.a  = m_read(rs1);
            case (op)
                6'h00: begin n.v = 1; n.b = m_read(rs2); n.aluop = if_instr[1:0]; n.we = (rd != 0); end
                6'h08: begin n.v = 1; n.b = imm; n.we = (rd != 0); end
                6'h23: begin n.v = 1; n.b = imm; n.we = (rd != 0); n.mrd = 1; end
                6'h2B: begin n.v = 1; n.b = imm; n.mwr = 1; n.sd = m_read(rd); end
                default: n = bubble();
            endcase
        end
        if (wb_we && wb_addr != 0) rf[wb_addr] = wb_data;
        ex_m = n;
    endtask

    task automatic check_ex();
        chk("ex_valid", ex_valid, ex_m.v);
        chk("ex_we", ex_we, ex_m.we);
        chk("ex_mem_rd", ex_mem_rd, ex_m.mrd);
        chk("ex_mem_wr", ex_mem_wr, ex_m.mwr);
        chk("ex_aluop", ex_aluop, ex_m.aluop);
        chk("ex_a", ex_a, ex_m.a);
        chk("ex_b", ex_b, ex_m.b);
        if (!ex_m.mwr) chk("ex_rd", ex_rd, ex_m.rd);
        if (ex_m.mwr || !ex_m.v) chk("ex_store_data", ex_store_data, ex_m.sd);
    endtask

    // Entered just after a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle();
        #1;
        stall_obs = if_stall;
        chk("if_stall", if_stall, (!ex_flush && m_hazard()));
        @(posedge clk);
        m_clock();
        #1;
        check_ex();
        @(negedge clk);
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rd, rs1, rs2, input logic [1:0] fn);
        return {6'h00, rd, rs1, rs2, 9'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rd, rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    task automatic idle();
        if_valid = 0; if_instr = 32'd0; ex_flush = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        idle();
        wb_we = 1; wb_addr = a; wb_data = d;
        cycle();
        wb_we = 0;
    endtask

    initial begin
        logic [5:0] ops [4];
        logic [5:0] op;
        logic [15:0] low;
        ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h23; ops[3] = 6'h2B;

        // Reset held with a valid instruction presented
        rst_n = 0;
        idle();
        if_valid = 1;
        if_instr = i_ins(6'h08, 5'd1, 5'd0, 16'd5);
        m_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_if_stall", if_stall, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_a", ex_a, 0);
        chk("rst_ex_b", ex_b, 0);
        chk("rst_ex_ctrl", {ex_we, ex_mem_rd, ex_mem_wr, ex_aluop, ex_rd}, 0);
        chk("rst_ex_sd", ex_store_data, 0);
        @(negedge clk);
        rst_n = 1;
        cycle();
        chk("first_addi_b", ex_b, 32'd5);
        chk("first_addi_valid", ex_valid, 1);

        // Preload and R-type SUB
        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd3);
        idle();
        if_valid = 1;
        if_instr = r_ins(5'd3, 5'd1, 5'd2, 2'd1);
        cycle();
        chk("sub_a", ex_a, 32'd5);
        chk("sub_b", ex_b, 32'd3);
        chk("sub_ctrl", {ex_valid, ex_we, ex_aluop, ex_rd}, {1'b1, 1'b1, 2'd1, 5'd3});

        // ADDI with negative immediate, then SW
        if_instr = i_ins(6'h08, 5'd4, 5'd1, 16'hFFFF);
        cycle();
        chk("addi_sext_b", ex_b, 32'hFFFF_FFFF);
        chk("addi_aluop", ex_aluop, 0);
        if_instr = i_ins(6'h2B, 5'd2, 5'd1, 16'd8);
        cycle();
        chk("sw_store_data", ex_store_data, 32'd3);
        chk("sw_ctrl", {ex_mem_wr, ex_we}, 2'b10);

        // Load-use stall, then issue
        if_instr = i_ins(6'h23, 5'd5, 5'd1, 16'd0);
        cycle();
        if_instr = r_ins(5'd6, 5'd5, 5'd0, 2'd0);
        cycle();
        chk("lu_stall", stall_obs, 1);
        chk("lu_bubble", ex_valid, 0);
        cycle();
        chk("lu_issue_stall", stall_obs, 0);
        chk("lu_issue_valid", ex_valid, 1);

        // Load to r0 never stalls
        if_instr = i_ins(6'h23, 5'd0, 5'd1, 16'd0);
        cycle();
        if_instr = r_ins(5'd6, 5'd0, 5'd0, 2'd0);
        cycle();
        chk("lw_r0_no_stall", stall_obs, 0);

        // Flush during a load-use stall
        if_instr = i_ins(6'h23, 5'd5, 5'd1, 16'd0);
        cycle();
        if_instr = r_ins(5'd6, 5'd5, 5'd0, 2'd0);
        ex_flush = 1;
        cycle();
        chk("flush_stall", stall_obs, 0);
        chk("flush_bubble", ex_valid, 0);
        ex_flush = 0;

        // Same-cycle writeback and read of r7
        wb_we = 1; wb_addr = 5'd7; wb_data = 32'hA5;
        if_instr = r_ins(5'd8, 5'd7, 5'd0, 2'd0);
        cycle();
`ifdef WB_BYPASS_EN
        chk("wb_same_cycle", ex_a, 32'hA5);
`else
        chk("wb_same_cycle", ex_a, 32'h0);
`endif
        wb_we = 1; wb_addr = 5'd0; wb_data = 32'hDEAD;
        if_instr = r_ins(5'd8, 5'd0, 5'd0, 2'd0);
        cycle();
        wb_we = 0;
        cycle();
        chk("r0_stays_zero", {ex_a, ex_b}, 64'd0);

        // Asynchronous reset in the middle of a stall
        if_instr = i_ins(6'h23, 5'd5, 5'd1, 16'd0);
        cycle();
        if_instr = r_ins(5'd6, 5'd5, 5'd0, 2'd0);
        #1;
        chk("pre_rst_stall", if_stall, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_stall", if_stall, 0);
        chk("mid_rst_valid", {ex_valid, ex_mem_rd}, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (!stall_obs) begin
                op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 3)];
                low = 16'($urandom);
                if (op == 6'h00) low[15:11] = 5'($urandom_range(0, 7));
                if_instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), low};
                if_valid = ($urandom_range(0, 99) < 85);
            end
            ex_flush = ($urandom_range(0, 99) < 10);
            wb_we    = $urandom_range(0, 1);
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
